vend_session_ctrl: RTL

//  Sequences one vending transaction: item select, rupee coin collection, dispense, change return.

---
 rtl/vend_pkg.sv | 16 +
 rtl/vend_session_ctrl_if.sv | 32 +++
 rtl/vend_stock_bank.sv | 30 +++
 rtl/vend_session_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending session controller.
// Money is counted in Rs 5 units throughout.
package vend_pkg;
    typedef enum logic [2:0] {IDLE, COLLECT, VEND, REFUND, CHANGE} state_t;

    localparam int NUM_ITEMS = 4;
    localparam int CREDIT_W  = 4;

    localparam logic [CREDIT_W-1:0] FIVE = CREDIT_W'(1);
    localparam logic [CREDIT_W-1:0] TEN  = CREDIT_W'(2);

    localparam logic [NUM_ITEMS-1:0] ITEM1 = 4'b0001;
    localparam logic [NUM_ITEMS-1:0] ITEM2 = 4'b0010;
    localparam logic [NUM_ITEMS-1:0] ITEM3 = 4'b0100;
    localparam logic [NUM_ITEMS-1:0] ITEM4 = 4'b1000;
endpackage

// File: rtl/vend_session_ctrl_if.sv
// Customer, coin-mech and hopper signals of one vending session.
interface vend_session_ctrl_if;
    import vend_pkg::*;

    logic [NUM_ITEMS-1:0] item_number;
    logic                 select_strobe;
    logic                 rupee_five_in;
    logic                 rupee_ten_in;
    logic                 cancel;
    logic                 restock;
    logic [NUM_ITEMS-1:0] restock_item;
    logic                 hopper_ack;
    logic                 dispense;
    logic [NUM_ITEMS-1:0] dispense_item;
    logic                 rupee_five_out;
    logic                 coin_reject;
    logic                 sold_out;
    logic                 busy;
    logic [CREDIT_W-1:0]  credit;

    modport master (
        output item_number, select_strobe, rupee_five_in, rupee_ten_in, cancel,
               restock, restock_item, hopper_ack,
        input  dispense, dispense_item, rupee_five_out, coin_reject, sold_out, busy, credit
    );

    modport slave (
        input  item_number, select_strobe, rupee_five_in, rupee_ten_in, cancel,
               restock, restock_item, hopper_ack,
        output dispense, dispense_item, rupee_five_out, coin_reject, sold_out, busy, credit
    );
endinterface

// File: rtl/vend_stock_bank.sv
// Per-item stock counters: reload on restock, saturating decrement on sale.
module vend_stock_bank
    import vend_pkg::*;
#(
    parameter int STOCK_INIT = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_ITEMS-1:0] load,
    input  logic [NUM_ITEMS-1:0] dec,
    output logic [NUM_ITEMS-1:0] empty
);
    localparam int STOCK_W = $clog2(STOCK_INIT + 1);
    localparam logic [STOCK_W-1:0] INIT = STOCK_W'(STOCK_INIT);

    for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_item
        logic [STOCK_W-1:0] cnt;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n)
                cnt <= INIT;
            else if (load[i])
                cnt <= INIT;
            else if (dec[i] && cnt != '0)
                cnt <= cnt - 1'b1;
        end

        assign empty[i] = (cnt == '0);
    end
endmodule

// File: rtl/vend_session_ctrl.sv
// One vending transaction: select, coin collection, dispense, change/refund via hopper.
// Moore outputs; credit is a single shared accumulator in Rs 5 units.
module vend_session_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE1      = 4,
    parameter int PRICE2      = 5,
    parameter int PRICE3      = 6,
    parameter int PRICE4      = 7,
    parameter int STOCK_INIT  = 8,
    parameter int TIMEOUT_CYC = 1000
) (
    input logic               clock,
    input logic               reset_n,
    vend_session_ctrl_if.slave bus
);
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_t               state;
    logic [NUM_ITEMS-1:0] item;
    logic [CREDIT_W-1:0]  price;
    logic [CREDIT_W-1:0]  credit;
    logic [TMO_W-1:0]     tmo;

    logic                 coin;
    logic [CREDIT_W-1:0]  sum;
    logic [CREDIT_W-1:0]  sel_price;
    logic                 sel_ok;
    logic [NUM_ITEMS-1:0] stock_empty;
    logic [NUM_ITEMS-1:0] stock_load;
    logic [NUM_ITEMS-1:0] stock_dec;

    always_comb begin
        coin = bus.rupee_five_in | bus.rupee_ten_in;
        sum  = credit + (bus.rupee_five_in ? FIVE : '0) + (bus.rupee_ten_in ? TEN : '0);
        case (bus.item_number)
            ITEM2:   sel_price = CREDIT_W'(PRICE2);
            ITEM3:   sel_price = CREDIT_W'(PRICE3);
            ITEM4:   sel_price = CREDIT_W'(PRICE4);
            default: sel_price = CREDIT_W'(PRICE1);
        endcase
        sel_ok     = $onehot(bus.item_number) && ((bus.item_number & stock_empty) == '0);
        stock_load = (state == IDLE && bus.restock) ? bus.restock_item : '0;
        stock_dec  = (state == VEND) ? item : '0;
    end

    vend_stock_bank #(.STOCK_INIT(STOCK_INIT)) u_stock (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (stock_load),
        .dec     (stock_dec),
        .empty   (stock_empty)
    );

    assign bus.credit = credit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            item               <= '0;
            price              <= '0;
            credit             <= '0;
            tmo                <= '0;
            bus.dispense       <= 1'b0;
            bus.dispense_item  <= '0;
            bus.rupee_five_out <= 1'b0;
            bus.coin_reject    <= 1'b0;
            bus.sold_out       <= 1'b0;
            bus.busy           <= 1'b0;
        end else begin
            bus.dispense      <= 1'b0;
            bus.dispense_item <= '0;
            bus.sold_out      <= 1'b0;
            bus.coin_reject   <= coin && (state != COLLECT);

            case (state)
                IDLE: begin
                    if (bus.select_strobe) begin
                        if (sel_ok) begin
                            item     <= bus.item_number;
                            price    <= sel_price;
                            tmo      <= '0;
                            state    <= COLLECT;
                            bus.busy <= 1'b1;
                        end else begin
                            bus.sold_out <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    credit <= sum;
                    tmo    <= coin ? '0 : tmo + 1'b1;
                    // Reaching the price beats a simultaneous cancel or timeout.
                    if (sum >= price) begin
                        state             <= VEND;
                        bus.dispense      <= 1'b1;
                        bus.dispense_item <= item;
                    end else if (bus.cancel || (!coin && tmo == TMO_LAST)) begin
                        state <= REFUND;
                    end
                end
                VEND: begin
                    credit <= credit - price;
                    if (credit != price) begin
                        state              <= CHANGE;
                        bus.rupee_five_out <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                REFUND: begin
                    if (credit != '0) begin
                        state              <= CHANGE;
                        bus.rupee_five_out <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                CHANGE: begin
                    // No timeout here: a stalled hopper holds the request forever.
                    if (bus.rupee_five_out && bus.hopper_ack) begin
                        credit <= credit - 1'b1;
                        if (credit == CREDIT_W'(1)) begin
                            bus.rupee_five_out <= 1'b0;
                            state              <= IDLE;
                            bus.busy           <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
